// File: rtl/instr_encoder_pkg.sv
// Shared RV32I definitions: opcodes, format/FSM enums, and the format
// decode and field-packing helpers used by the encoder and the field decoder.
package instr_encoder_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL
  } fmt_e;

  typedef enum logic {ST_IDLE, ST_WRITE} wr_state_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } instr_fields_t;

  function automatic fmt_e decode_fmt(input logic [6:0] op);
    case (op)
      OP_R:                                   decode_fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:    decode_fmt = FMT_I;
      OP_STORE:                               decode_fmt = FMT_S;
      OP_BRANCH:                              decode_fmt = FMT_B;
      OP_LUI, OP_AUIPC:                       decode_fmt = FMT_U;
      OP_JAL:                                 decode_fmt = FMT_J;
      default:                                decode_fmt = FMT_ILLEGAL;
    endcase
  endfunction

  function automatic logic [31:0] encode(input instr_fields_t f, input fmt_e fmt);
    logic [31:0] w;
    w = '0;
    case (fmt)
      FMT_R: w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I: begin
        // shift-immediates carry funct7 above a 5-bit shamt
        if (f.opcode == OP_IMM && (f.funct3 == 3'b001 || f.funct3 == 3'b101))
          w = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
        else
          w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      end
      FMT_S: w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B: w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                  f.imm[4:1], f.imm[11], f.opcode};
      FMT_U: w = {f.imm[31:12], f.rd, f.opcode};
      FMT_J: w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Power-of-two circular buffer of encoded instruction words; head is
// presented combinationally on rdata.
module instr_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic do_push, do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // pointers wrap naturally because depth is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder: packs fields into a 32-bit word, buffers it,
// and streams words to instruction memory at consecutive addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        addr_clr,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        err
);
  instr_fields_t fields;
  fmt_e          fmt;
  wr_state_e     state_q, state_d;
  logic [31:0]   enc_word, head, next_addr, load_addr;
  logic          accept, push, pop, load, full, empty;

  always_comb begin
    fields.opcode = opcode;
    fields.rd     = rd_addr;
    fields.rs1    = rs1_addr;
    fields.rs2    = rs2_addr;
    fields.funct3 = funct3;
    fields.funct7 = funct7;
    fields.imm    = imm;
  end

  assign fmt      = decode_fmt(opcode);
  assign enc_word = encode(fields, fmt);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  // illegal bundles are consumed but never enqueued
  assign push     = accept && (fmt != FMT_ILLEGAL);

  instr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (enc_word),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // head stays buffered until acked, so pop only happens in WRITE
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (mem_ack) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // next_addr always names the address of the next load; a clear anywhere
  // before that load redirects it to BASE_ADDR
  assign load_addr = addr_clr ? BASE_ADDR : next_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      next_addr <= BASE_ADDR;
      err       <= 1'b0;
    end else begin
      if (load) begin
        mem_addr  <= load_addr;
        mem_wdata <= head;
        next_addr <= load_addr + 32'd4;
      end else if (addr_clr) begin
        next_addr <= BASE_ADDR;
      end
      if (accept && fmt == FMT_ILLEGAL) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with an address/data scoreboard.
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd_addr = '0, rs1_addr = '0, rs2_addr = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        addr_clr = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b1;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [31:0] model_addr = BASE;

  instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .funct3(funct3), .funct7(funct7), .imm(imm), .addr_clr(addr_clr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // negedge: compare any active write against the scoreboard head
  task automatic tick();
    @(negedge clk);
    if (mem_we) begin
      if (sb.size() == 0) begin
        chk("write_without_expectation", 64'(sb.size()), 64'd1);
      end else begin
        chk("mem_addr", {32'b0, mem_addr}, {32'b0, sb[0][63:32]});
        chk("mem_wdata", {32'b0, mem_wdata}, {32'b0, sb[0][31:0]});
        if (mem_ack) void'(sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im, input logic [31:0] word, input bit legal);
    int n;
    opcode = op; rd_addr = rd; rs1_addr = r1; rs2_addr = r2;
    funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n == 100) chk("accept_timeout", 64'(in_ready), 64'd1);
    if (legal) begin
      sb.push_back({model_addr, word});
      model_addr = model_addr + 32'd4;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || mem_we) && n < 200) begin tick(); n++; end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    sb.delete();
    model_addr = BASE;
    tick();
  endtask

  initial begin
    mem_ack = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", {32'b0, mem_addr}, {32'b0, BASE});
    chk("rst_mem_wdata", {32'b0, mem_wdata}, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // add x3,x1,x2 with explicit 2-cycle latency check
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b1);
    chk("lat_we_cycle1", 64'(mem_we), 64'd0);
    tick();
    chk("lat_we_cycle2", 64'(mem_we), 64'd1);
    chk("add_addr", {32'b0, mem_addr}, 64'h0);
    chk("add_word", {32'b0, mem_wdata}, 64'h002081B3);
    drain();

    do_reset();
    // addi / sw / beq / lui / shifts / jal back to back
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b1);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020A423, 1'b1);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h00208463, 1'b1);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b1);
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd3, 32'h00309093, 1'b1);
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 32'hFFFFFFE3, 32'h4030D093, 1'b1);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000801, 32'h001000EF, 1'b1);
    drain();

    // backpressure: ack held low, four fill the buffer, fifth is refused
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++)
      send(7'b0110011, 5'(3 + i), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,
           32'h002081B3 + 32'(i) * 32'h80, 1'b1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    opcode = 7'b0110011; rd_addr = 5'd7; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_hold_in_ready", 64'(in_ready), 64'd0);
      chk("full_hold_we", 64'(mem_we), 64'd1);
    end
    in_valid = 1'b0;
    mem_ack = 1'b1;
    drain();

    // illegal opcode: consumed, not written, sticky err
    send(7'b1111111, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'd0, 1'b0);
    chk("illegal_err", 64'(err), 64'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("illegal_no_we", 64'(mem_we), 64'd0);
    chk("illegal_err_sticky", 64'(err), 64'd1);
    chk("illegal_in_ready", 64'(in_ready), 64'd1);

    // addr_clr during the write at 0x8
    do_reset();
    chk("reset_clears_err", 64'(err), 64'd0);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b1);
    send(7'b0110011, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00208233, 1'b1);
    drain();
    mem_ack = 1'b0;
    send(7'b0110011, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002082B3, 1'b1);
    tick();
    chk("clr_pre_addr", {32'b0, mem_addr}, 64'h8);
    addr_clr = 1'b1;
    tick();
    addr_clr = 1'b0;
    chk("clr_hold_we", 64'(mem_we), 64'd1);
    chk("clr_hold_addr", {32'b0, mem_addr}, 64'h8);
    model_addr = BASE;
    mem_ack = 1'b1;
    send(7'b0110011, 5'd6, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00208333, 1'b1);
    drain();

    // reset mid-write with a buffered word behind it
    mem_ack = 1'b0;
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b1);
    send(7'b0110011, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00208233, 1'b1);
    chk("midrst_pre_we", 64'(mem_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_we_low", 64'(mem_we), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    tick();
    rst = 1'b0;
    model_addr = BASE;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("midrst_no_stale_we", 64'(mem_we), 64'd0);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b1);
    tick();
    chk("midrst_first_addr", {32'b0, mem_addr}, {32'b0, BASE});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: instruction buffer entries, power of two, 2..16.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: first instruction-memory write address.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1: field bundle present.
REQ-006 SHALL have port in_ready  out  1: bundle accepted this cycle when in_valid is also high.
REQ-007 SHALL have ports opcode in 7, rd_addr in 5, rs1_addr in 5, rs2_addr in 5, funct3 in 3, funct7 in 7: RV32I instruction fields.
REQ-008 SHALL have port imm  in  32: unencoded immediate (byte offset or value).
REQ-009 SHALL have port addr_clr  in  1: restart the write address at BASE_ADDR.
REQ-010 SHALL have ports mem_we out 1, mem_addr out 32, mem_wdata out 32: instruction-memory write request.
REQ-011 SHALL have port mem_ack  in  1: memory accepted the write.
REQ-012 SHALL have port err  out  1: sticky flag, illegal opcode seen.

Function
REQ-013 SHALL drive in_ready = !full; no push/pop bypass when full.
REQ-014 SHALL select the format from opcode: R 0110011; I 0010011/0000011/1100111/1110011; S 0100011; B 1100011; U 0110111/0010111; J 1101111.
REQ-015 SHALL pack fields per format: I imm[11:0]; S imm[11:5] and imm[4:0]; B imm[12|10:5] and imm[4:1|11]; U imm[31:12]; J imm[20|10:1|11|19:12]; imm[0] is ignored for B and J.
REQ-016 SHALL place funct7 in [31:25] and imm[4:0] in [24:20] for opcode 0010011 with funct3 001 or 101 (shift-immediates).
REQ-017 SHALL consume a bundle with an illegal opcode (in_ready high), not enqueue it, and set err the next cycle.
REQ-018 SHALL encode combinationally and write the 32-bit word into the FIFO on the accepting edge.
REQ-019 SHALL run a two-state writer FSM. IDLE: if the FIFO is non-empty, load the head into mem_addr/mem_wdata, then go to WRITE. WRITE: mem_we=1.
REQ-020 SHALL hold mem_we, mem_addr and mem_wdata stable in WRITE until mem_ack. On mem_ack: pop, next address += 4, return to IDLE.
REQ-021 SHALL give an accept-to-mem_we latency of 2 cycles when the FIFO is empty and the FSM is in IDLE. Peak throughput is one write per 2 cycles.
REQ-022 SHALL wrap the address modulo 2^32 with no error.
REQ-023 SHALL leave an outstanding WRITE unaffected by addr_clr; the next loaded write uses BASE_ADDR. addr_clr takes priority over a same-cycle +4 increment.
REQ-024 SHALL allow a push and a pop in the same cycle when the FIFO is neither empty nor full; occupancy is unchanged.
REQ-025 SHALL ignore mem_ack while in IDLE.

Reset
REQ-026 SHALL, while rst is high, clear: FIFO pointers/occupancy (empty), FSM to IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, next address=BASE_ADDR, err=0. in_ready SHALL be 1 after release.
REQ-027 SHALL abandon an in-flight WRITE and discard buffered words on reset mid-operation, with no mem_we glitch after rst rises.

Structure
REQ-028 SHALL take opcode constants, format enum (R/I/S/B/U/J/ILLEGAL) and FSM state encoding from the shared RISC-V package also used by the field decoder.
REQ-029 SHALL implement the buffer as one sub-module, instr_fifo (parameter FIFO_DEPTH, 32-bit data, push/pop/full/empty).

Verification
REQ-030 SHALL check: add x3,x1,x2 (op 0110011, rd 3, rs1 1, rs2 2, f3 0, f7 0) after reset with ack held high -> mem_wdata 32'h002081B3, mem_addr 32'h0.
REQ-031 SHALL check: addi x1,x0,imm 32'hFFFFFFFF, then sw x2,8(x1) -> 32'hFFF00093 at 0x0, then 32'h0020A423 at 0x4.
REQ-032 SHALL check: beq x1,x2,imm 8 -> 32'h00208463; lui x5,imm 32'h12345000 -> 32'h123452B7.
REQ-033 SHALL check: mem_ack held low with 5 bundles offered -> 4 accepted then in_ready low; mem_we/addr/data stable throughout; on ack release, all 4 written in order at +4 steps.
REQ-034 SHALL check: opcode 7'b1111111 offered -> consumed, nothing written, err high until reset; addr_clr during WRITE at 0x8 -> current write completes at 0x8 and the next goes to BASE_ADDR.
REQ-035 SHALL check: rst asserted mid-WRITE -> mem_we low immediately and the FIFO empty; the first write after release is at BASE_ADDR.
